// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state machine and parity encodings,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // data_xor is the XOR of all data bits; odd parity transmits its inverse.
  function automatic logic parity_bit(input logic data_xor, input int parity);
    return (parity == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/bclk_tick.sv
// Rising-edge detector for the baud-rate bit clock: one single-cycle tick
// per bit time, synchronous to clk.
module bclk_tick (
  input  logic clk,
  input  logic reset,
  input  logic bclk,
  output logic tick
);

  logic bclk_q;

  // Reset still tracks bclk so a high bclk at release does not look like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_q <= bclk;
    end else begin
      bclk_q <= bclk;
    end
  end

  assign tick = bclk & ~bclk_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop
// frame shifter, advanced one bit per bclk tick.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bclk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(STOP_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
    $fatal(1, "uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_e            state;
  logic                   tick;
  logic                   hold_full;
  logic [DATA_BITS-1:0]   hold_data;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   load;

  bclk_tick u_bclk_tick (
    .clk   (clk),
    .reset (reset),
    .bclk  (bclk),
    .tick  (tick)
  );

  // Holding register drains into the shifter from IDLE or at the end of the
  // last stop bit; both paths share this single load strobe.
  always_comb begin
    load = 1'b0;
    if (tick && hold_full) begin
      load = (state == ST_IDLE) || (state == ST_STOP && bit_cnt == CNT_STOP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      if (load) begin
        shift_q   <= hold_data;
        par_q     <= parity_bit(^hold_data, PARITY);
        hold_full <= 1'b0;
      end else if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      if (tick) begin
        unique case (state)
          ST_IDLE: begin
            if (hold_full) begin
              state   <= ST_START;
              tx      <= 1'b0;
              bit_cnt <= '0;
            end
          end
          ST_START: begin
            state   <= ST_DATA;
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_cnt <= CNT_ONE;
          end
          ST_DATA: begin
            if (bit_cnt == CNT_DATA) begin
              if (PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                tx    <= par_q;
              end else begin
                state   <= ST_STOP;
                tx      <= 1'b1;
                bit_cnt <= CNT_ONE;
              end
            end else begin
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
          ST_PARITY: begin
            state   <= ST_STOP;
            tx      <= 1'b1;
            bit_cnt <= CNT_ONE;
          end
          ST_STOP: begin
            if (bit_cnt == CNT_STOP) begin
              state   <= hold_full ? ST_START : ST_IDLE;
              tx      <= ~hold_full;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign busy     = (state != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: several frame formats, hand-computed frame
// table, randomized words against a bit-list frame model, and corner sequences.
module tb_uart_tx;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bclk = 1'b0;
  int   bph = 15;
  bit   bclk_run = 1'b1;

  logic [7:0] td0 = '0;
  logic [7:0] td1 = '0;
  logic [7:0] td2 = '0;
  logic [4:0] td3 = '0;
  logic [8:0] td4 = '0;
  logic tv  [NI];
  logic tr  [NI];
  logic txl [NI];
  logic bs  [NI];

  int cfg_bits [NI] = '{8, 8, 8, 5, 9};
  int cfg_par  [NI] = '{0, 2, 1, 1, 0};
  int cfg_stop [NI] = '{1, 2, 1, 2, 1};

  int checks = 0;
  int failures = 0;
  bit exp_q [$];

  always #5 clk = ~clk;

  // 16-cycle bit clock, updated shortly after each rising clk edge.
  always begin
    @(posedge clk);
    #2;
    if (bclk_run) begin
      bph  = (bph + 1) % 16;
      bclk = (bph < 8);
    end
  end

  uart_tx u_8n1 (
    .clk(clk), .reset(reset), .bclk(bclk), .tx_data(td0), .tx_valid(tv[0]),
    .tx_ready(tr[0]), .tx(txl[0]), .busy(bs[0])
  );
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .reset(reset), .bclk(bclk), .tx_data(td1), .tx_valid(tv[1]),
    .tx_ready(tr[1]), .tx(txl[1]), .busy(bs[1])
  );
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .bclk(bclk), .tx_data(td2), .tx_valid(tv[2]),
    .tx_ready(tr[2]), .tx(txl[2]), .busy(bs[2])
  );
  uart_tx #(.DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) u_5o2 (
    .clk(clk), .reset(reset), .bclk(bclk), .tx_data(td3), .tx_valid(tv[3]),
    .tx_ready(tr[3]), .tx(txl[3]), .busy(bs[3])
  );
  uart_tx #(.DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
    .clk(clk), .reset(reset), .bclk(bclk), .tx_data(td4), .tx_valid(tv[4]),
    .tx_ready(tr[4]), .tx(txl[4]), .busy(bs[4])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic set_data(input int inst, input logic [8:0] d);
    case (inst)
      0: td0 = d[7:0];
      1: td1 = d[7:0];
      2: td2 = d[7:0];
      3: td3 = d[4:0];
      default: td4 = d;
    endcase
  endtask

  // Frame model: start 0, data LSB-first, optional parity, stop 1s.
  function automatic void model_frame(input int inst, input logic [8:0] d);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < cfg_bits[inst]; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (cfg_par[inst] == 2) exp_q.push_back((ones % 2) == 1);
    else if (cfg_par[inst] == 1) exp_q.push_back((ones % 2) == 0);
    for (int i = 0; i < cfg_stop[inst]; i++) exp_q.push_back(1'b1);
  endfunction

  task automatic wait_start(input int inst, input string nm, input bit chk_ready);
    int n = 0;
    int rdy_bad = 0;
    @(negedge clk);
    while (txl[inst] !== 1'b0 && n < 60) begin
      if (chk_ready && n > 0 && tr[inst] !== 1'b0) rdy_bad++;
      @(negedge clk);
      n++;
    end
    chk({nm, " start_seen"}, 32'(n < 60), 1);
    if (chk_ready) begin
      chk({nm, " ready_low_until_start"}, rdy_bad, 0);
      chk({nm, " ready_at_start"}, tr[inst], 1);
    end
  endtask

  // Called on the first sample of the start bit; every bit must hold 16 cycles.
  task automatic check_stream(input int inst, input string nm);
    int bad_bit = -1;
    int busy_bad = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      for (int j = 0; j < 16; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (txl[inst] !== exp_q[k] && bad_bit < 0) bad_bit = k;
        if (bs[inst] !== 1'b1) busy_bad++;
      end
    end
    chk({nm, " first_bad_bit"}, bad_bit, -1);
    chk({nm, " busy_in_frame"}, busy_bad, 0);
    @(negedge clk);
    chk({nm, " idle_tx"}, txl[inst], 1);
    chk({nm, " idle_busy"}, bs[inst], 0);
    chk({nm, " idle_ready"}, tr[inst], 1);
  endtask

  task automatic send_single(input int inst, input logic [8:0] d, input string nm);
    fork
      begin
        @(negedge clk);
        chk({nm, " ready_before"}, tr[inst], 1);
        set_data(inst, d);
        tv[inst] = 1'b1;
        @(negedge clk);
        tv[inst] = 1'b0;
        chk({nm, " ready_after_accept"}, tr[inst], 0);
        chk({nm, " busy_after_accept"}, bs[inst], 1);
      end
      begin
        wait_start(inst, nm, 1'b1);
        check_stream(inst, nm);
      end
    join
  endtask

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic [15:0] frame;  // bit 0 = start bit
    int         len;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int n;
    int lows;
    logic [8:0] d;
    logic [15:0] fr;
    for (int i = 0; i < NI; i++) tv[i] = 1'b0;

    vecs.push_back('{0, 9'h055, 16'h02AA, 10});
    vecs.push_back('{0, 9'h0FF, 16'h03FE, 10});
    vecs.push_back('{0, 9'h000, 16'h0200, 10});
    vecs.push_back('{1, 9'h007, 16'h0E0E, 12});
    vecs.push_back('{1, 9'h000, 16'h0C00, 12});
    vecs.push_back('{2, 9'h007, 16'h040E, 11});
    vecs.push_back('{2, 9'h000, 16'h0600, 11});
    vecs.push_back('{3, 9'h01F, 16'h01BE, 9});
    vecs.push_back('{3, 9'h001, 16'h0182, 9});
    vecs.push_back('{4, 9'h1FF, 16'h07FE, 11});
    vecs.push_back('{4, 9'h100, 16'h0600, 11});

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_tx[%0d]", i), txl[i], 1);
      chk($sformatf("reset_ready[%0d]", i), tr[i], 1);
      chk($sformatf("reset_busy[%0d]", i), bs[i], 0);
    end

    for (int v = 0; v < vecs.size(); v++) begin
      exp_q.delete();
      fr = vecs[v].frame;
      for (int k = 0; k < vecs[v].len; k++) exp_q.push_back(fr[k]);
      send_single(vecs[v].inst, vecs[v].data, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 15; r++) begin
      int inst;
      inst = int'($urandom_range(0, NI - 1));
      d = 9'($urandom);
      exp_q.delete();
      model_frame(inst, d);
      send_single(inst, d, $sformatf("rnd%0d_i%0d_d%0h", r, inst, d));
    end

    // Back-to-back frames with tx_valid held high.
    exp_q.delete();
    model_frame(0, 9'h0A5);
    model_frame(0, 9'h03C);
    fork
      begin
        @(negedge clk);
        set_data(0, 9'h0A5);
        tv[0] = 1'b1;
        @(negedge clk);
        set_data(0, 9'h03C);
        n = 0;
        while (tr[0] !== 1'b1 && n < 60) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        tv[0] = 1'b0;
      end
      begin
        wait_start(0, "b2b", 1'b0);
        check_stream(0, "b2b");
      end
    join

    // Word accepted on the same edge as an IDLE tick waits for the next tick.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bph != 0 && n < 40);
    set_data(0, 9'h03C);
    tv[0] = 1'b1;
    @(negedge clk);
    tv[0] = 1'b0;
    n = 1;
    while (txl[0] !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("tick_accept start_delay", n, 17);
    exp_q.delete();
    model_frame(0, 9'h03C);
    check_stream(0, "tick_accept");

    // Holding register full while tx_valid toggles with junk data.
    exp_q.delete();
    model_frame(0, 9'h05A);
    model_frame(0, 9'h0C3);
    fork
      begin
        int rdy_bad = 0;
        @(negedge clk);
        set_data(0, 9'h05A);
        tv[0] = 1'b1;
        @(negedge clk);
        tv[0] = 1'b0;
        n = 0;
        while (tr[0] !== 1'b1 && n < 60) begin
          @(negedge clk);
          n++;
        end
        set_data(0, 9'h0C3);
        tv[0] = 1'b1;
        @(negedge clk);
        tv[0] = 1'b0;
        for (int c = 0; c < 80; c++) begin
          @(negedge clk);
          if (tr[0] !== 1'b0) rdy_bad++;
          set_data(0, 9'($urandom));
          tv[0] = 1'($urandom);
        end
        tv[0] = 1'b0;
        chk("hold_full ready_low", rdy_bad, 0);
      end
      begin
        wait_start(0, "hold_full", 1'b0);
        check_stream(0, "hold_full");
      end
    join

    // Reset during data bit 3 discards the frame and the held word.
    fork
      begin
        @(negedge clk);
        set_data(0, 9'h000);
        tv[0] = 1'b1;
        @(negedge clk);
        tv[0] = 1'b0;
        n = 0;
        while (tr[0] !== 1'b1 && n < 60) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        set_data(0, 9'h0FF);
        tv[0] = 1'b1;
        @(negedge clk);
        tv[0] = 1'b0;
      end
      begin
        wait_start(0, "rst_mid", 1'b0);
        repeat (16 * 4 + 4) @(negedge clk);
        chk("rst_mid tx_before", txl[0], 0);
        chk("rst_mid held_before", tr[0], 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid tx_after", txl[0], 1);
        chk("rst_mid ready_after", tr[0], 1);
        chk("rst_mid busy_after", bs[0], 0);
        reset = 1'b0;
      end
    join
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (txl[0] !== 1'b1) lows++;
    end
    chk("rst_mid quiet_tx", lows, 0);
    chk("rst_mid quiet_busy", bs[0], 0);

    // bclk stops mid-frame: state and line level freeze.
    fork
      begin
        @(negedge clk);
        set_data(0, 9'h00F);
        tv[0] = 1'b1;
        @(negedge clk);
        tv[0] = 1'b0;
      end
      begin
        wait_start(0, "bclk_stop", 1'b0);
        repeat (16 * 2 + 4) @(negedge clk);
        chk("bclk_stop tx_d1", txl[0], 1);
        bclk_run = 1'b0;
        lows = 0;
        repeat (100) begin
          @(negedge clk);
          if (txl[0] !== 1'b1 || bs[0] !== 1'b1) lows++;
        end
        chk("bclk_stop frozen", lows, 0);
        bclk_run = 1'b1;
        n = 0;
        while (bs[0] !== 1'b0 && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("bclk_stop resumes_to_idle", 32'(n < 400), 1);
      end
    join

    // Reset released while bclk is high: start waits for the next rising edge.
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bph != 3 && n < 40);
    reset = 1'b0;
    set_data(0, 9'h081);
    tv[0] = 1'b1;
    @(negedge clk);
    tv[0] = 1'b0;
    wait_start(0, "rel_high", 1'b0);
    chk("rel_high start_phase", bph, 1);
    exp_q.delete();
    model_frame(0, 9'h081);
    check_stream(0, "rel_high");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for all state.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port bclk, input, 1 bit: bit clock from the baud-rate generator, synchronous to clk, period equal to one bit time.
REQ-007 SHALL have port tx_data, input, DATA_BITS bits: byte to transmit.
REQ-008 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-009 SHALL have port tx_ready, output, 1 bit: the holding register is empty and can accept data.
REQ-010 SHALL have port tx, output, 1 bit: registered serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in flight or the holding register is full.

Function
REQ-012 SHALL abort elaboration with a fatal error when any parameter is outside its legal range.
REQ-013 SHALL register bclk into bclk_q every cycle and derive tick = bclk AND NOT bclk_q, giving exactly one tick per bit time.
REQ-014 SHALL accept a word when tx_valid AND tx_ready are high on a rising clk edge, loading tx_data into a one-entry holding register.
REQ-015 SHALL drive tx_ready = NOT holding-register-full, so tx_ready goes low the cycle after acceptance and tx_data is ignored while it is low.
REQ-016 SHALL implement the state machine IDLE, START, DATA, PARITY, STOP; every state transition occurs only on a tick.
REQ-017 In IDLE, tx = 1; on a tick with the holding register full, the block SHALL move the word to the shifter, empty the holding register, enter START, and set tx to 0.
REQ-018 A word accepted in the same cycle as a tick in IDLE SHALL start on the following tick, not the current one.
REQ-019 START SHALL last one bit time; DATA SHALL then shift DATA_BITS bits out LSB-first, one per tick, with a bit counter of width clog2(DATA_BITS+1).
REQ-020 PARITY SHALL be entered only when PARITY != 0 and SHALL last one bit time. The transmitted bit is the XOR of the data bits for even parity and its inverse for odd parity.
REQ-021 STOP SHALL drive tx = 1 for STOP_BITS bit times.
REQ-022 On the tick ending the last stop bit, the block SHALL go directly to START (tx = 0) if the holding register is full, otherwise to IDLE, so back-to-back frames have zero idle gap.
REQ-023 The holding register MAY accept a new word at any point during a frame; the handshake SHALL never corrupt the frame in flight.
REQ-024 SHALL drive busy = (state != IDLE) OR holding-register-full.
REQ-025 bclk is expected to be continuous; if bclk stops, the block SHALL hold its current state and tx level indefinitely.

Reset
REQ-026 While reset is high, at each clk edge the block SHALL set state to IDLE, tx to 1, empty the holding register (tx_ready = 1), set busy to 0, clear the bit counter, and set bclk_q to bclk so no spurious tick follows reset release.
REQ-027 A reset asserted mid-frame SHALL return tx to 1 at the next edge, discarding both the frame in flight and any held word.

Structure
REQ-028 The state enum and the parity encoding constants (NONE/ODD/EVEN) SHALL live in a shared package, uart_pkg, reused by the receiver.
REQ-029 One sub-module, bclk_tick (bclk rising-edge detector), SHALL be used; the baud-rate generator is instantiated by the parent, not inside uart_tx.

Verification (bclk period = 16 clk cycles unless noted)
REQ-030 8N1, send 0x55 -> tx reads 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles; tx_ready low from the cycle after acceptance until the START tick.
REQ-031 8N1, 0xA5 then 0x3C with tx_valid held high -> second start bit begins on the tick ending the first stop bit, with no idle gap; busy stays high throughout.
REQ-032 PARITY = 2, send 0x07 -> parity bit = 1; PARITY = 1, send 0x07 -> parity bit = 0; STOP_BITS = 2 -> tx high for 32 cycles before IDLE.
REQ-033 Reset pulsed during data bit 3 -> tx = 1, tx_ready = 1, busy = 0 at the next edge; no further tx transitions without new data.
REQ-034 Holding register full plus tx_valid toggling with new data -> the held word is unchanged and the transmitted bytes match only the accepted words.
REQ-035 Reset released while bclk = 1 -> no tick and no START until the next bclk rising edge.
